capture_arbiter: RTL
====================

# capture_arbiter

Two-requester, round-robin arbiter that shares a single registered capture stage between two launch paths. Each launch path (a flop fed from its own clock-tree tap) offers a data word through a valid/ready handshake. The arbiter grants one requester at a time, registers the word into the shared capture register, and hands it downstream. A programmable guard interval follows each transfer, so that back-to-back captures from differently skewed launch domains are spaced apart.

## Interface
- WIDTH, 8, data word width in bits (1..64)
- GUARD, 2, idle cycles inserted after each completed output transfer (0..15)

- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, synchronous and active-high
- req0_valid  input  1  requester 0 offers req0_data
- req0_data  input  WIDTH  requester 0 word
- req0_ready  output  1  arbiter accepts requester 0 this cycle
- req1_valid  input  1  requester 1 offers req1_data
- req1_data  input  WIDTH  requester 1 word
- req1_ready  output  1  arbiter accepts requester 1 this cycle
- out_valid  output  1  capture register holds a word
- out_data  output  WIDTH  captured word
- out_src  output  1  source of out_data (0 = requester 0, 1 = requester 1)
- out_ready  input  1  downstream accepts out_data
- xfer_cnt  output  8  count of completed output transfers; wraps from 255 to 0

## Operation
- The block has three states: IDLE, HOLD and GUARD. Reset places it in IDLE.
- **Reset values:**
  - out_valid = 0, out_data = 0, out_src = 0, xfer_cnt = 0.
  - The round-robin pointer `last` = 1, so requester 0 wins the first contention.
  - The guard counter = 0.
- **IDLE:**
  - Only one requester valid: that requester is the winner.
  - Both valid: the requester not equal to `last` is the winner.
  - Winner's ready = 1 combinationally; the other ready = 0.
  - No requester valid: both readys = 0.
  - On a handshake (valid & ready):
    - out_data ← winner data; out_src ← winner; `last` ← winner.
    - out_valid ← 1; next state is HOLD.
- **HOLD:**
  - Both readys = 0; out_data and out_src stay stable.
  - On out_valid & out_ready: out_valid ← 0 and xfer_cnt ← xfer_cnt + 1 (mod 256).
  - Next state after that handshake: GUARD with counter ← GUARD−1 if GUARD > 0; otherwise IDLE.
- **GUARD:**
  - Both readys = 0.
  - Counter = 0: next state is IDLE. Otherwise the counter decrements.
- req*_ready has no combinational path from out_ready or from the data inputs. It depends only on the state, the valids and `last`.
- Requesters hold valid and data until they are accepted. The arbiter re-evaluates the winner every IDLE cycle. A requester that drops valid before acceptance is simply not granted.
- A single active requester may be granted on consecutive rounds. The pointer does not block it.
- **Reset mid-operation:** any word held in HOLD is discarded. out_valid is 0 in the cycle after rst is sampled high, and all state returns to its reset values. xfer_cnt does not count the discarded word.
- out_data is held, not cleared, after the output handshake until the next capture.

## Timing
- Capture latency: a requester handshake at edge N gives out_valid = 1 from cycle N+1.
- An output handshake at edge M clears out_valid in cycle M+1. The earliest next requester handshake is at edge M+1+GUARD.
- Minimum period between captures is 2+GUARD cycles when out_ready is held at 1.
- With both requesters continuously valid and out_ready = 1, grants strictly alternate 0,1,0,1…
- HOLD has no timeout; it stalls indefinitely while out_ready = 0.

## Test plan
- **Reset, then single capture:**
  - Hold rst = 1 for 2 cycles: all outputs read 0.
  - Then req0_valid = 1, data 0xA5, out_ready = 1.
  - Required: req0_ready = 1 in the first post-reset cycle; out_valid = 1 with out_data 0xA5 and out_src 0 one cycle later; xfer_cnt = 1 after the output handshake.
- **Contention fairness (GUARD = 2):**
  - Both requesters continuously valid (0x11 and 0x22), out_ready = 1.
  - Required: output sequence 0x11, 0x22, 0x11, 0x22.
  - Required: out_valid rising edges are exactly 4 cycles apart.
- **Backpressure:**
  - After a capture, hold out_ready = 0 for 5 cycles.
  - Required: out_valid stays 1 and out_data stays stable; both readys stay 0; xfer_cnt is unchanged until out_ready = 1.
- **GUARD = 0, single requester:**
  - req1 continuously valid with incrementing data, out_ready = 1.
  - Required: a capture every 2 cycles; out_src always 1; no gaps caused by the round-robin pointer.
- **Reset mid-HOLD:**
  - Capture 0x3C, keep out_ready = 0, then assert rst for 1 cycle.
  - Required: out_valid = 0 on the next cycle; xfer_cnt = 0; with both requesters valid, the next grant goes to requester 0.
- **Counter wrap:** 256 transfers, then 1 more. Required: xfer_cnt reads 0, then 1.

Source files
------------

// File: rtl/capture_arbiter.sv
// capture_arbiter: two-requester round-robin arbiter feeding one shared capture register, with a guard gap after each transfer
module capture_arbiter #(
  parameter int WIDTH = 8,
  parameter int GUARD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [7:0]       xfer_cnt
);
  localparam logic [1:0] S_IDLE = 2'd0, S_HOLD = 2'd1, S_GUARD = 2'd2;
  logic [1:0] state;
  logic [3:0] gcnt;
  logic       last, grant, idle;
  // winner selection; readies see only state, valids and the round-robin pointer
  always_comb begin
    idle = state == S_IDLE;
    grant = (req0_valid && req1_valid) ? ~last : req1_valid;
    req0_ready = idle && req0_valid && !grant;
    req1_ready = idle && req1_valid && grant;
  end
  // capture on grant, hold until drained, then space the next capture by the guard interval
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      gcnt <= '0;
      last <= 1'b1;
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= 1'b0;
      xfer_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (req0_ready || req1_ready) begin
        out_data <= grant ? req1_data : req0_data;
        out_src <= grant;
        last <= grant;
        out_valid <= 1'b1;
        state <= S_HOLD;
      end
    end else if (state == S_HOLD) begin
      if (out_ready) begin
        out_valid <= 1'b0;
        xfer_cnt <= xfer_cnt + 8'd1;
        state <= (GUARD > 0) ? S_GUARD : S_IDLE;
        gcnt <= 4'((GUARD > 0) ? GUARD - 1 : 0);
      end
    end else if (gcnt == 4'd0) begin
      state <= S_IDLE;
    end else begin
      gcnt <= gcnt - 4'd1;
    end
  end
endmodule
